// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder: debounced 7-seg bus snooper rebuilding hex nibbles; `SEVSEG_DP_CAPTURE_EN adds DpOut.
module seven_seg_scan_decoder #(
    parameter int NUM_DIGITS    = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [7:0]              SegIn,
    input  logic [NUM_DIGITS-1:0]   DigSel,
    output logic [4*NUM_DIGITS-1:0] Value,
    output logic [NUM_DIGITS-1:0]   DigValid,
    output logic [NUM_DIGITS-1:0]   DigErr,
`ifdef SEVSEG_DP_CAPTURE_EN
    output logic [NUM_DIGITS-1:0]   DpOut,
`endif
    output logic                    FrameDone
);
`ifdef SEVSEG_DP_CAPTURE_EN
    localparam int KW = 8;
`else
    localparam int KW = 7;
    logic unused_dp;
    assign unused_dp = SegIn[7];
`endif
    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
    localparam logic [6:0] SEG_LUT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [KW-1:0]           key_q, key_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d, vld_q, vld_d, err_q, err_d, mask_q, mask_d, dp_q, dp_d;
    logic [4*NUM_DIGITS-1:0] val_q, val_d;
    logic                    done_q, done_d, cap, hit;
    logic [3:0]              nib;
    always_comb begin
        hit = 1'b0;
        nib = '0;
        for (int k = 0; k < 16; k++) begin
            if (SegIn[6:0] == SEG_LUT[k]) begin
                hit = 1'b1;
                nib = 4'(k);
            end
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        sel_d   = sel_q;
        val_d   = val_q;
        vld_d   = vld_q;
        err_d   = err_q;
        mask_d  = mask_q;
        dp_d    = dp_q;
        done_d  = 1'b0;
        cap     = 1'b0;
        if (!$onehot(DigSel)) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == IDLE || SegIn[KW-1:0] != key_q || DigSel != sel_q) begin
            key_d   = SegIn[KW-1:0];
            sel_d   = DigSel;
            cnt_d   = 8'd1;
            cap     = STABLE == 8'd1;
            state_d = cap ? HOLD : SETTLE;
        end else if (state_q == SETTLE) begin
            cnt_d   = cnt_q + 8'd1;
            cap     = cnt_d == STABLE;
            state_d = cap ? HOLD : SETTLE;
        end
        // Capture targets the strobed digit; the latched pair equals the live one here.
        if (cap) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (DigSel[i]) begin
                    val_d[4*i +: 4] = hit ? nib : val_q[4*i +: 4];
                    err_d[i]        = !hit;
                    vld_d[i]        = 1'b1;
                    dp_d[i]         = SegIn[7];
                end
            end
            mask_d = mask_q | DigSel;
            done_d = &mask_d;
            mask_d = done_d ? '0 : mask_d;
        end
    end
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
            sel_q   <= '0;
            val_q   <= '0;
            vld_q   <= '0;
            err_q   <= '0;
            mask_q  <= '0;
            dp_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            sel_q   <= sel_d;
            val_q   <= val_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            dp_q    <= dp_d;
            done_q  <= done_d;
        end
    end
    assign Value     = val_q;
    assign DigValid  = vld_q;
    assign DigErr    = err_q;
    assign FrameDone = done_q;
`ifdef SEVSEG_DP_CAPTURE_EN
    assign DpOut     = dp_q;
`else
    logic unused_dpq;
    assign unused_dpq = |dp_q;
`endif
endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// tb_seven_seg_scan_decoder: random + directed stimulus against a run-length reference model with a queued scoreboard.
module tb_seven_seg_scan_decoder;
    localparam int N = 2;
    localparam int S = 4;
    localparam logic [6:0] PAT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    typedef struct packed {
        logic [4*N-1:0] val;
        logic [N-1:0]   vld;
        logic [N-1:0]   err;
        logic [N-1:0]   dp;
        logic           done;
    } exp_t;
    logic           Clk = 1'b0;
    logic           Rst = 1'b1;
    logic [7:0]     SegIn = '0;
    logic [N-1:0]   DigSel = '0;
    logic [4*N-1:0] Value;
    logic [N-1:0]   DigValid, DigErr, DpOut;
    logic           FrameDone;
    exp_t           exp_q [$];
    exp_t           m;
    int             vectors = 0;
    int             miscompares = 0;
    int             run = 0;
    logic [7:0]     last_seg;
    logic [N-1:0]   last_sel, mask;
    seven_seg_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .Clk(Clk), .Rst(Rst), .SegIn(SegIn), .DigSel(DigSel), .Value(Value),
        .DigValid(DigValid), .DigErr(DigErr),
`ifdef SEVSEG_DP_CAPTURE_EN
        .DpOut(DpOut),
`endif
        .FrameDone(FrameDone)
    );
`ifndef SEVSEG_DP_CAPTURE_EN
    assign DpOut = '0;
`endif
    always #5 Clk = ~Clk;
    function automatic logic [7:0] key(input logic [7:0] s);
`ifdef SEVSEG_DP_CAPTURE_EN
        return s;
`else
        return {1'b0, s[6:0]};
`endif
    endfunction
    // Reference: a digit is captured exactly when the same one-hot pair has been seen S edges in a row.
    task automatic step(input logic [7:0] seg, input logic [N-1:0] sel, input logic r);
        @(negedge Clk);
        Rst = r;
        SegIn = seg;
        DigSel = sel;
        m.done = 1'b0;
        if (r) begin
            m = '0;
            run = 0;
            mask = '0;
        end else if ($countones(sel) != 1) begin
            run = 0;
        end else begin
            run = (run == 0 || key(seg) != key(last_seg) || sel != last_sel) ? 1 : run + 1;
            last_seg = seg;
            last_sel = sel;
            if (run == S) begin
                for (int d = 0; d < N; d++) begin
                    if (sel[d]) begin
                        m.err[d] = 1'b1;
                        for (int k = 0; k < 16; k++) begin
                            if (seg[6:0] == PAT[k]) begin
                                m.val[4*d +: 4] = 4'(k);
                                m.err[d] = 1'b0;
                            end
                        end
                        m.vld[d] = 1'b1;
                        m.dp[d] = seg[7];
                    end
                end
                mask = mask | sel;
                if (&mask) begin
                    m.done = 1'b1;
                    mask = '0;
                end
            end
        end
        exp_q.push_back(m);
    endtask
    task automatic hold(input logic [N-1:0] sel, input logic [7:0] seg, input int cycles);
        for (int c = 0; c < cycles; c++) step(seg, sel, 1'b0);
    endtask
    always @(posedge Clk) begin
        #2;
        if (exp_q.size() != 0) begin
            exp_t e;
            logic bad;
            e = exp_q.pop_front();
            bad = 1'b0;
            vectors++;
            if (Value !== e.val) begin
                $display("FAIL value t=%0t got %h want %h", $time, Value, e.val);
                bad = 1'b1;
            end
            if (DigValid !== e.vld) begin
                $display("FAIL digvalid t=%0t got %b want %b", $time, DigValid, e.vld);
                bad = 1'b1;
            end
            if (DigErr !== e.err) begin
                $display("FAIL digerr t=%0t got %b want %b", $time, DigErr, e.err);
                bad = 1'b1;
            end
            if (FrameDone !== e.done) begin
                $display("FAIL framedone t=%0t got %b want %b", $time, FrameDone, e.done);
                bad = 1'b1;
            end
`ifdef SEVSEG_DP_CAPTURE_EN
            if (DpOut !== e.dp) begin
                $display("FAIL dpout t=%0t got %b want %b", $time, DpOut, e.dp);
                bad = 1'b1;
            end
`endif
            if (bad) miscompares++;
        end
    end
    initial begin
        m = '0;
        mask = '0;
        last_seg = '0;
        last_sel = '0;
        step(8'h00, '0, 1'b1);
        step(8'h00, '0, 1'b1);
        hold(2'b01, 8'h4F, 4);
        hold(2'b10, 8'h7C, 4);
        hold(2'b01, 8'h06, 3);
        hold(2'b01, 8'h5B, 4);
        hold(2'b01, 8'h00, 4);
        hold(2'b11, 8'h3F, 10);
        hold(2'b00, 8'h3F, 10);
        hold(2'b01, 8'h71, 2);
        step(8'h71, 2'b01, 1'b1);
        hold(2'b01, 8'h71, 4);
        hold(2'b10, 8'hEF, 4);
        hold(2'b10, 8'h6F, 5);
        for (int t = 0; t < 400; t++) begin
            logic [7:0]   seg;
            logic [N-1:0] sel;
            int           p;
            p = int'($urandom_range(0, 99));
            seg = {1'($urandom), (p < 80) ? PAT[$urandom_range(0, 15)] : 7'($urandom)};
            sel = (p % 10 == 0) ? N'($urandom) : N'(1 << $urandom_range(0, N - 1));
            if (p == 99) step(seg, sel, 1'b1);
            else hold(sel, seg, int'($urandom_range(1, 7)));
        end
        for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(posedge Clk);
        #3;
        if (exp_q.size() != 0) begin
            $display("FAIL drain %0d entries left, want 0", exp_q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
